// File: rtl/digit_box_overlay.sv
// digit_box_overlay: draws per-frame latched 1-pixel outlines around up to three digits on an RGB565 stream (2-cycle video delay; box_valid/digit_cnt/ovl_active report committed boxes)
module digit_box_overlay #(
  parameter int          H_PIXEL   = 320,
  parameter int          V_PIXEL   = 240,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ovl_en,
  input  logic        frame_vs_fall,
  input  logic [10:0] hcount_l1,
  input  logic [10:0] hcount_r1,
  input  logic [10:0] hcount_l2,
  input  logic [10:0] hcount_r2,
  input  logic [10:0] hcount_l3,
  input  logic [10:0] hcount_r3,
  input  logic [10:0] vcount_l1,
  input  logic [10:0] vcount_r1,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        pix_de_i,
  input  logic        pix_hs_i,
  input  logic        pix_vs_i,
  input  logic [15:0] pix_data_i,
  output logic        pix_de_o,
  output logic        pix_hs_o,
  output logic        pix_vs_o,
  output logic [15:0] pix_data_o,
  output logic [2:0]  box_valid,
  output logic [1:0]  digit_cnt,
  output logic        ovl_active
);
  localparam logic [10:0] H_MAX = 11'(H_PIXEL - 1);
  localparam logic [10:0] V_MAX = 11'(V_PIXEL - 1);
  typedef enum logic {S_IDLE, S_DRAW} state_t;
  state_t r_state, w_next;
  logic w_commit, w_clear;
  logic [10:0] w_l [3];
  logic [10:0] w_r [3];
  logic [10:0] w_vt, w_vb;
  logic [2:0] w_valid, w_hit;
  logic [1:0] w_cnt;
  logic [10:0] r_l [3];
  logic [10:0] r_r [3];
  logic [10:0] r_vt, r_vb;
  logic [2:0] r_valid;
  logic [1:0] r_cnt;
  logic r_de1, r_hs1, r_vs1, r_de2, r_hs2, r_vs2;
  logic [15:0] r_data1, r_data2;
  logic [10:0] r_hc1, r_vc1;
  logic w_in_v, w_hedge;
  always_comb begin
    w_next   = frame_vs_fall ? (ovl_en ? S_DRAW : S_IDLE) : r_state;
    w_commit = frame_vs_fall && ovl_en;
    w_clear  = frame_vs_fall && !ovl_en;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_l[0] = hcount_l1[10] ? '0 : hcount_l1;
    w_l[1] = hcount_l2[10] ? '0 : hcount_l2;
    w_l[2] = hcount_l3[10] ? '0 : hcount_l3;
    w_r[0] = hcount_r1 > H_MAX ? H_MAX : hcount_r1;
    w_r[1] = hcount_r2 > H_MAX ? H_MAX : hcount_r2;
    w_r[2] = hcount_r3 > H_MAX ? H_MAX : hcount_r3;
    w_vt   = vcount_l1[10] ? '0 : vcount_l1;
    w_vb   = vcount_r1 > V_MAX ? V_MAX : vcount_r1;
    w_cnt  = 2'(w_valid[0]) + 2'(w_valid[1]) + 2'(w_valid[2]);
  end
  assign w_in_v  = r_vc1 >= r_vt && r_vc1 <= r_vb;
  assign w_hedge = r_vc1 == r_vt || r_vc1 == r_vb;
  for (genvar k = 0; k < 3; k++) begin : g_box
    assign w_valid[k] = w_l[k] < w_r[k] && w_vt < w_vb;
    assign w_hit[k] = r_valid[k] &&
      (((r_hc1 == r_l[k] || r_hc1 == r_r[k]) && w_in_v) ||
       (w_hedge && r_hc1 >= r_l[k] && r_hc1 <= r_r[k]));
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_l     <= '{default: '0};
      r_r     <= '{default: '0};
      r_vt    <= '0;
      r_vb    <= '0;
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (w_commit) begin
      r_l     <= w_l;
      r_r     <= w_r;
      r_vt    <= w_vt;
      r_vb    <= w_vb;
      r_valid <= w_valid;
      r_cnt   <= w_cnt;
    end else if (w_clear) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end
  always_ff @(posedge clk)
    if (rst) begin
      {r_de1, r_hs1, r_vs1, r_data1, r_hc1, r_vc1} <= '0;
      {r_de2, r_hs2, r_vs2, r_data2} <= '0;
    end else begin
      {r_de1, r_hs1, r_vs1, r_data1} <= {pix_de_i, pix_hs_i, pix_vs_i, pix_data_i};
      {r_hc1, r_vc1} <= {hcount, vcount};
      {r_de2, r_hs2, r_vs2} <= {r_de1, r_hs1, r_vs1};
      r_data2 <= (r_state == S_DRAW && r_de1 && |w_hit) ? BOX_COLOR : r_data1;
    end
  assign {pix_de_o, pix_hs_o, pix_vs_o, pix_data_o} = {r_de2, r_hs2, r_vs2, r_data2};
  assign box_valid  = r_valid;
  assign digit_cnt  = r_cnt;
  assign ovl_active = r_state == S_DRAW;
endmodule
